// File: rtl/siphash_stream_ctrl.sv
// Byte-stream front end for the SipHash core: packs message bytes into
// little-endian 64-bit words, applies length padding and sequences core commands.
module siphash_stream_ctrl #(
    parameter int unsigned COMPRESSION_ROUNDS = 2,
    parameter int unsigned FINAL_ROUNDS       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          msg_empty,
    input  logic [127:0]  key,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          busy,
    output logic [63:0]   tag,
    output logic          tag_valid,
    output logic          core_initalize,
    output logic          core_compress,
    output logic          core_finalize,
    output logic          core_long,
    output logic [3:0]    core_compression_rounds,
    output logic [3:0]    core_final_rounds,
    output logic [127:0]  core_key,
    output logic [63:0]   core_mi,
    input  logic          core_ready,
    input  logic [127:0]  core_word,
    input  logic          core_word_valid
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned LANE_W = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_GAP_I,
        S_COLLECT,
        S_PAD,
        S_COMPRESS,
        S_WAIT_C,
        S_FINAL,
        S_WAIT_T
    } state_t;

    state_t              state, state_nxt;
    logic [KEY_W-1:0]    key_reg, key_nxt;
    logic [WORD_W-1:0]   word_reg, word_nxt;
    logic [LANE_W-1:0]   lane, lane_nxt;
    logic [LEN_W-1:0]    len_reg, len_nxt;
    logic                empty_flag, empty_nxt;
    logic                last_seen, last_seen_nxt;
    logic                final_pending, final_pending_nxt;
    logic                in_ready_nxt;
    logic                busy_nxt;
    logic [WORD_W-1:0]   tag_nxt;
    logic                tag_valid_nxt;
    logic                init_nxt, comp_nxt, fin_nxt;
    logic [WORD_W-1:0]   core_mi_nxt;
    logic                accept_c;

    assign core_long               = 1'b0;
    assign core_compression_rounds = 4'(COMPRESSION_ROUNDS);
    assign core_final_rounds       = 4'(FINAL_ROUNDS);
    assign core_key                = key_reg;
    assign accept_c                = in_valid && in_ready;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            key_reg        <= '0;
            word_reg       <= '0;
            lane           <= '0;
            len_reg        <= '0;
            empty_flag     <= 1'b0;
            last_seen      <= 1'b0;
            final_pending  <= 1'b0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            tag            <= '0;
            tag_valid      <= 1'b0;
            core_initalize <= 1'b0;
            core_compress  <= 1'b0;
            core_finalize  <= 1'b0;
            core_mi        <= '0;
        end else begin
            state          <= state_nxt;
            key_reg        <= key_nxt;
            word_reg       <= word_nxt;
            lane           <= lane_nxt;
            len_reg        <= len_nxt;
            empty_flag     <= empty_nxt;
            last_seen      <= last_seen_nxt;
            final_pending  <= final_pending_nxt;
            in_ready       <= in_ready_nxt;
            busy           <= busy_nxt;
            tag            <= tag_nxt;
            tag_valid      <= tag_valid_nxt;
            core_initalize <= init_nxt;
            core_compress  <= comp_nxt;
            core_finalize  <= fin_nxt;
            core_mi        <= core_mi_nxt;
        end
    end

    // Next-state and next-output logic; command pulses coincide with INIT, WAIT_C entry and FINAL
    always_comb begin
        state_nxt         = state;
        key_nxt           = key_reg;
        word_nxt          = word_reg;
        lane_nxt          = lane;
        len_nxt           = len_reg;
        empty_nxt         = empty_flag;
        last_seen_nxt     = last_seen;
        final_pending_nxt = final_pending;
        tag_nxt           = tag;
        tag_valid_nxt     = tag_valid;
        core_mi_nxt       = core_mi;
        init_nxt          = 1'b0;
        comp_nxt          = 1'b0;
        fin_nxt           = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    key_nxt           = key;
                    empty_nxt         = msg_empty;
                    word_nxt          = '0;
                    lane_nxt          = '0;
                    len_nxt           = '0;
                    last_seen_nxt     = 1'b0;
                    final_pending_nxt = 1'b0;
                    tag_valid_nxt     = 1'b0;
                    init_nxt          = 1'b1;
                    state_nxt         = S_INIT;
                end
            end
            S_INIT: state_nxt = S_GAP_I;
            S_GAP_I: state_nxt = empty_flag ? S_PAD : S_COLLECT;
            S_COLLECT: begin
                if (accept_c) begin
                    word_nxt[{lane, 3'b000} +: 8] = in_data;
                    lane_nxt = lane + LANE_W'(1);
                    len_nxt  = len_reg + LEN_W'(1);
                    if (lane == LANE_W'(7)) begin
                        last_seen_nxt = in_last;
                        state_nxt     = S_COMPRESS;
                    end else if (in_last) begin
                        state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                word_nxt[63:56]   = len_reg;
                final_pending_nxt = 1'b1;
                state_nxt         = S_COMPRESS;
            end
            S_COMPRESS: begin
                if (core_ready) begin
                    comp_nxt    = 1'b1;
                    core_mi_nxt = word_reg;
                    word_nxt    = '0;
                    state_nxt   = S_WAIT_C;
                end
            end
            S_WAIT_C: begin
                // The pulse cycle itself is skipped: the core drops ready only one cycle later
                if (core_ready && !core_compress) begin
                    if (final_pending) begin
                        fin_nxt   = 1'b1;
                        state_nxt = S_FINAL;
                    end else if (last_seen) begin
                        word_nxt          = {len_reg, 56'h0};
                        final_pending_nxt = 1'b1;
                        state_nxt         = S_COMPRESS;
                    end else begin
                        state_nxt = S_COLLECT;
                    end
                end
            end
            S_FINAL: state_nxt = S_WAIT_T;
            S_WAIT_T: begin
                if (core_ready && core_word_valid) begin
                    tag_nxt       = core_word[127:64] ^ core_word[63:0];
                    tag_valid_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        in_ready_nxt = (state_nxt == S_COLLECT);
        busy_nxt     = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_siphash_stream_ctrl.sv
// Self-checking bench for siphash_stream_ctrl with a behavioural SipHash core responder
// and a message-level SipHash-2-4 reference model.
module tb_siphash_stream_ctrl;

    typedef logic [7:0]       byte_q_t[$];
    typedef logic [63:0]      word_q_t[$];
    typedef logic [3:0][63:0] sv_t;

    localparam logic [127:0] TEST_KEY = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
    localparam int unsigned  C_ROUNDS = 2;
    localparam int unsigned  D_ROUNDS = 4;
    localparam int unsigned  BUDGET   = 5000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         msg_empty = 1'b0;
    logic [127:0] key = '0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready, busy, tag_valid;
    logic [63:0]  tag;
    logic         core_initalize, core_compress, core_finalize, core_long;
    logic [3:0]   core_compression_rounds, core_final_rounds;
    logic [127:0] core_key;
    logic [63:0]  core_mi;
    logic         core_ready;
    logic [127:0] core_word;
    logic         core_word_valid;

    int n_cmp = 0;
    int n_err = 0;

    siphash_stream_ctrl #(.COMPRESSION_ROUNDS(2), .FINAL_ROUNDS(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .msg_empty(msg_empty), .key(key),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .busy(busy), .tag(tag), .tag_valid(tag_valid),
        .core_initalize(core_initalize), .core_compress(core_compress),
        .core_finalize(core_finalize), .core_long(core_long),
        .core_compression_rounds(core_compression_rounds),
        .core_final_rounds(core_final_rounds), .core_key(core_key), .core_mi(core_mi),
        .core_ready(core_ready), .core_word(core_word), .core_word_valid(core_word_valid)
    );

    always #5 clk = ~clk;

    // ---------------- SipHash arithmetic ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned s);
        return (x << s) | (x >> (64 - s));
    endfunction

    function automatic sv_t sip_round(input sv_t vi);
        sv_t v = vi;
        v[0] = v[0] + v[1]; v[1] = rotl(v[1], 13); v[1] = v[1] ^ v[0]; v[0] = rotl(v[0], 32);
        v[2] = v[2] + v[3]; v[3] = rotl(v[3], 16); v[3] = v[3] ^ v[2];
        v[0] = v[0] + v[3]; v[3] = rotl(v[3], 21); v[3] = v[3] ^ v[0];
        v[2] = v[2] + v[1]; v[1] = rotl(v[1], 17); v[1] = v[1] ^ v[2]; v[2] = rotl(v[2], 32);
        return v;
    endfunction

    function automatic sv_t sip_init(input logic [127:0] k);
        sv_t v;
        v[0] = k[63:0]   ^ 64'h736f6d6570736575;
        v[1] = k[127:64] ^ 64'h646f72616e646f6d;
        v[2] = k[63:0]   ^ 64'h6c7967656e657261;
        v[3] = k[127:64] ^ 64'h7465646279746573;
        return v;
    endfunction

    function automatic sv_t sip_compress(input sv_t vi, input logic [63:0] m);
        sv_t v = vi;
        v[3] = v[3] ^ m;
        for (int r = 0; r < int'(C_ROUNDS); r++) v = sip_round(v);
        v[0] = v[0] ^ m;
        return v;
    endfunction

    function automatic logic [63:0] sip_final(input sv_t vi);
        sv_t v = vi;
        v[2] = v[2] ^ 64'hff;
        for (int r = 0; r < int'(D_ROUNDS); r++) v = sip_round(v);
        return v[0] ^ v[1] ^ v[2] ^ v[3];
    endfunction

    // Message -> padded little-endian words (last word carries length mod 256 in byte 7)
    function automatic void ref_words(input byte_q_t m, output word_q_t w);
        int          n = m.size();
        logic [63:0] cur;
        w = {};
        for (int i = 0; i < n / 8; i++) begin
            cur = '0;
            for (int b = 0; b < 8; b++) cur[8*b +: 8] = m[8*i + b];
            w.push_back(cur);
        end
        cur = '0;
        for (int b = 0; b < n % 8; b++) cur[8*b +: 8] = m[8*(n/8) + b];
        cur[63:56] = 8'(n % 256);
        w.push_back(cur);
    endfunction

    function automatic logic [63:0] ref_siphash(input logic [127:0] k, input byte_q_t m);
        word_q_t w;
        sv_t     v;
        ref_words(m, w);
        v = sip_init(k);
        foreach (w[i]) v = sip_compress(v, w[i]);
        return sip_final(v);
    endfunction

    // ---------------- Core responder ----------------
    logic        cm_ready, cm_wv, cm_fin;
    logic [127:0] cm_word;
    logic [63:0] cm_tag, cm_mask;
    sv_t         cm_v;
    int          cm_cnt;
    int          init_cnt, fin_cnt;
    word_q_t     mi_q;

    assign core_ready      = cm_ready;
    assign core_word       = cm_word;
    assign core_word_valid = cm_wv;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cm_ready <= 1'b1; cm_wv <= 1'b0; cm_fin <= 1'b0; cm_word <= '0;
            cm_tag <= '0; cm_mask <= '0; cm_v <= '0; cm_cnt <= 0;
        end else begin
            cm_mask <= {$urandom, $urandom};
            if (core_initalize) begin
                cm_v     <= sip_init(core_key);
                cm_wv    <= 1'b0;
                init_cnt <= init_cnt + 1;
            end else if (core_compress) begin
                cm_v     <= sip_compress(cm_v, core_mi);
                mi_q.push_back(core_mi);
                cm_ready <= 1'b0;
                cm_cnt   <= int'($urandom_range(1, 4));
            end else if (core_finalize) begin
                cm_tag   <= sip_final(cm_v);
                cm_fin   <= 1'b1;
                cm_ready <= 1'b0;
                cm_cnt   <= int'($urandom_range(1, 6));
                fin_cnt  <= fin_cnt + 1;
            end else if (cm_cnt != 0) begin
                cm_cnt <= cm_cnt - 1;
                if (cm_cnt == 1) begin
                    cm_ready <= 1'b1;
                    if (cm_fin) begin
                        cm_wv   <= 1'b1;
                        cm_word <= {cm_mask, cm_mask ^ cm_tag};
                        cm_fin  <= 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        init_cnt = 0;
        fin_cnt  = 0;
    end

    // Command protocol monitor: one pulse max, only with ready, never back to back
    int   viol = 0;
    logic prev_cmd = 1'b0;
    always @(negedge clk) begin
        int ncmd;
        ncmd = int'(core_initalize) + int'(core_compress) + int'(core_finalize);
        if (reset_n) begin
            if (ncmd > 1) viol <= viol + 1;
            if (ncmd != 0 && !core_ready) viol <= viol + 1;
            if (ncmd != 0 && prev_cmd) viol <= viol + 1;
            prev_cmd <= (ncmd != 0);
        end else begin
            prev_cmd <= 1'b0;
        end
    end

    // ---------------- Driver ----------------
    task automatic run_hash(input logic [127:0] k, input byte_q_t msg, input int gap_pct,
                            input bit poke_start, output bit timeout);
        int idx = 0;
        int cyc = 0;
        bit acc;
        @(negedge clk);
        start = 1'b1; msg_empty = (msg.size() == 0); key = k;
        @(negedge clk);
        start = 1'b0; key = {$urandom, $urandom, $urandom, $urandom};
        while (idx < msg.size() && cyc < int'(BUDGET)) begin
            start = poke_start && (cyc == 150);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
            end else begin
                in_valid = 1'b1; in_data = msg[idx]; in_last = (idx == msg.size() - 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        while (!tag_valid && cyc < int'(BUDGET)) begin
            @(negedge clk);
            cyc++;
        end
        timeout = (cyc >= int'(BUDGET));
    endtask

    function automatic byte_q_t rand_msg(input int n);
        byte_q_t m = {};
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    // ---------------- Tests ----------------
    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (tag !== 64'h0) begin n_err++; $display("FAIL reset_tag got %h exp 0", tag); end
        n_cmp++; if (tag_valid !== 1'b0) begin n_err++; $display("FAIL reset_tag_valid got %b exp 0", tag_valid); end
        n_cmp++; if ({core_initalize, core_compress, core_finalize} !== 3'b000) begin
            n_err++; $display("FAIL reset_cmds got %b exp 000", {core_initalize, core_compress, core_finalize}); end
        n_cmp++; if (core_key !== 128'h0) begin n_err++; $display("FAIL reset_core_key got %h exp 0", core_key); end
        n_cmp++; if ({core_long, core_compression_rounds, core_final_rounds} !== 9'b0_0010_0100) begin
            n_err++; $display("FAIL core_cfg got %b exp 001000100", {core_long, core_compression_rounds, core_final_rounds}); end
    endtask

    task automatic test_vectors();
        logic [63:0] exp_tag[3]  = '{64'h726fdb47dd0e0e31, 64'h93f5f5799a932462, 64'ha129ca6149be45e5};
        logic [63:0] exp_last[3] = '{64'h0, 64'h0800000000000000, 64'h0f0e0d0c0b0a0908};
        int          lens[3]     = '{0, 8, 15};
        byte_q_t     m;
        bit          to;
        int          base, ib, fb;
        for (int t = 0; t < 3; t++) begin
            m = {};
            for (int i = 0; i < lens[t]; i++) m.push_back(8'(i));
            base = mi_q.size(); ib = init_cnt; fb = fin_cnt;
            run_hash(TEST_KEY, m, 0, 1'b0, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL vec%0d_timeout no tag_valid", t); end
            n_cmp++; if (tag !== exp_tag[t]) begin n_err++; $display("FAIL vec%0d_tag got %h exp %h", t, tag, exp_tag[t]); end
            n_cmp++; if (tag_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_tag_valid got %b exp 1", t, tag_valid); end
            n_cmp++; if (mi_q.size() - base !== (t == 0 ? 1 : 2)) begin
                n_err++; $display("FAIL vec%0d_ncompress got %0d exp %0d", t, mi_q.size() - base, (t == 0 ? 1 : 2)); end
            else begin
                n_cmp++; if (mi_q[mi_q.size()-1] !== exp_last[t]) begin
                    n_err++; $display("FAIL vec%0d_last_mi got %h exp %h", t, mi_q[mi_q.size()-1], exp_last[t]); end
                if (t == 1) begin
                    n_cmp++; if (mi_q[base] !== 64'h0706050403020100) begin
                        n_err++; $display("FAIL vec1_first_mi got %h exp 0706050403020100", mi_q[base]); end
                end
            end
            n_cmp++; if (init_cnt - ib !== 1 || fin_cnt - fb !== 1) begin
                n_err++; $display("FAIL vec%0d_cmd_counts got init %0d fin %0d exp 1 1", t, init_cnt - ib, fin_cnt - fb); end
        end
    endtask

    task automatic check_hash(input string nm, input logic [127:0] k, input byte_q_t m,
                              input int base, input bit to);
        word_q_t     w;
        logic [63:0] et;
        ref_words(m, w);
        et = ref_siphash(k, m);
        n_cmp++; if (to) begin n_err++; $display("FAIL %s_timeout no tag_valid", nm); end
        n_cmp++; if (tag !== et) begin n_err++; $display("FAIL %s_tag got %h exp %h", nm, tag, et); end
        n_cmp++; if (core_key !== k) begin n_err++; $display("FAIL %s_core_key got %h exp %h", nm, core_key, k); end
        n_cmp++; if (mi_q.size() - base !== w.size()) begin
            n_err++; $display("FAIL %s_nwords got %0d exp %0d", nm, mi_q.size() - base, w.size()); end
        else begin
            foreach (w[i]) begin
                n_cmp++; if (mi_q[base + i] !== w[i]) begin
                    n_err++; $display("FAIL %s_mi%0d got %h exp %h", nm, i, mi_q[base + i], w[i]); end
            end
        end
    endtask

    task automatic test_handshake();
        byte_q_t      m;
        logic [127:0] k;
        bit           to;
        int           base, v0;
        v0 = viol;
        for (int t = 0; t < 8; t++) begin
            m = rand_msg(int'($urandom_range(0, 40)));
            k = {$urandom, $urandom, $urandom, $urandom};
            base = mi_q.size();
            run_hash(k, m, 40, 1'b0, to);
            check_hash($sformatf("hs%0d", t), k, m, base, to);
        end
        n_cmp++; if (viol !== v0) begin n_err++; $display("FAIL cmd_protocol violations got %0d exp %0d", viol, v0); end
    endtask

    task automatic test_long_wrap();
        byte_q_t      m;
        logic [127:0] k;
        logic [63:0]  exp_last;
        bit           to;
        int           base, ib;
        m = rand_msg(300);
        k = {$urandom, $urandom, $urandom, $urandom};
        exp_last = {8'h2c, 24'h0, m[299], m[298], m[297], m[296]};
        base = mi_q.size(); ib = init_cnt;
        run_hash(k, m, 20, 1'b1, to);
        check_hash("long", k, m, base, to);
        n_cmp++; if (mi_q.size() - base !== 38 || mi_q[mi_q.size()-1] !== exp_last) begin
            n_err++; $display("FAIL long_pad_word got %h exp %h", mi_q[mi_q.size()-1], exp_last); end
        n_cmp++; if (init_cnt - ib !== 1) begin n_err++; $display("FAIL long_busy_start init pulses got %0d exp 1", init_cnt - ib); end
    endtask

    task automatic test_back_to_back();
        byte_q_t      m;
        logic [127:0] k;
        logic [63:0]  held;
        bit           to;
        int           base;
        held = tag;
        repeat (5) @(negedge clk);
        n_cmp++; if (tag_valid !== 1'b1 || tag !== held) begin
            n_err++; $display("FAIL hold_tag got %b/%h exp 1/%h", tag_valid, tag, held); end
        for (int t = 0; t < 2; t++) begin
            m = rand_msg(int'($urandom_range(1, 24)));
            k = {$urandom, $urandom, $urandom, $urandom};
            base = mi_q.size();
            run_hash(k, m, 0, 1'b0, to);
            check_hash($sformatf("b2b%0d", t), k, m, base, to);
        end
    endtask

    task automatic test_reset_mid();
        int          cyc = 0;
        bit          to;
        byte_q_t     m;
        @(negedge clk);
        start = 1'b1; msg_empty = 1'b0; key = TEST_KEY;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'haa; in_last = 1'b0;
        while (!core_compress && cyc < 100) begin @(negedge clk); cyc++; end
        n_cmp++; if (cyc >= 100) begin n_err++; $display("FAIL rst_mid_no_compress got none exp pulse"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready, busy, tag_valid, core_initalize, core_compress, core_finalize} !== 6'b0
                     || tag !== 64'h0 || core_key !== 128'h0 || core_mi !== 64'h0) begin
            n_err++; $display("FAIL rst_mid_outputs got %b tag %h key %h mi %h exp all zero",
                {in_ready, busy, tag_valid, core_initalize, core_compress, core_finalize}, tag, core_key, core_mi); end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m = {};
        run_hash(TEST_KEY, m, 0, 1'b0, to);
        n_cmp++; if (to || tag !== 64'h726fdb47dd0e0e31) begin
            n_err++; $display("FAIL rst_mid_rehash got %h exp 726fdb47dd0e0e31", tag); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_vectors();
        test_handshake();
        test_long_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
